// File: rtl/sarray_arb_pkg.sv
// -----------------------------------------------------------------------------
// sarray_arb_pkg
// Shared types and constants for the systolic-array read-channel arbiter.
//   SARRAY_ARB_NUM_REQ          number of requesters sharing the read channel
//   SARRAY_ARB_MAX_OUTSTANDING  default tag FIFO depth
//   arb_tag_t                   requester ID carried through the tag FIFO
//   arb_cnt_t                   FIFO occupancy type (0..MAX_OUTSTANDING)
// Width macros `ADDR_WIDTH and `SARRAY_LOAD_WIDTH are given fallback values
// here when the surrounding build does not provide them.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 32
`endif

package sarray_arb_pkg;
   localparam int SARRAY_ARB_NUM_REQ         = 2;
   localparam int SARRAY_ARB_MAX_OUTSTANDING = 8;

   typedef logic [0:0] arb_tag_t;
   typedef logic [$clog2(SARRAY_ARB_MAX_OUTSTANDING):0] arb_cnt_t;
endpackage

// File: rtl/sarray_tag_fifo.sv
// -----------------------------------------------------------------------------
// sarray_tag_fifo
// Small in-order FIFO: synchronous write, combinational read of the head entry.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push         write push_data (ignored while full)
//   push_data    entry to write
//   pop          retire head entry (ignored while empty)
//   head_data    current head entry (meaningless while empty)
//   full, empty  occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sarray_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW:0]      count_reg;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_en;
   logic             pop_en;

   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_en, pop_en})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage is not reset: entries are only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr_reg] <= push_data;
   end

   assign head_data = mem[rd_ptr_reg];
   assign full      = (count_reg == DEPTH[PW:0]);
   assign empty     = (count_reg == '0);
endmodule

// File: rtl/sarray_rd_arb.sv
// -----------------------------------------------------------------------------
// sarray_rd_arb
// Shares one memory read channel (AR/R) between two requesters. One AR is
// granted at a time; the winner's ID is queued in an in-order tag FIFO and
// each returning R beat is steered to the requester at the FIFO head.
// Both paths are combinational (no added latency).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   mN_ar_valid_i/ready_o/addr_i     requester N read-address channel
//   mN_r_valid_o/ready_i/data_o      requester N read-data channel
//   s_ar_valid_o/ready_i/addr_o      downstream read-address channel
//   s_r_valid_i/ready_o/data_i       downstream read-data channel
// Configuration macro:
//   SARRAY_RD_ARB_RR_EN  defined  : round-robin between simultaneous requests
//                        undefined: fixed priority, m0 over m1
// A pending (valid, not yet accepted) grant is locked so the downstream
// address stays stable regardless of the arbitration mode.
// -----------------------------------------------------------------------------
module sarray_rd_arb
   import sarray_arb_pkg::*;
#(
   parameter int ADDR_WIDTH      = `ADDR_WIDTH,
   parameter int DATA_WIDTH      = `SARRAY_LOAD_WIDTH,
   parameter int MAX_OUTSTANDING = SARRAY_ARB_MAX_OUTSTANDING
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_ar_valid_i,
   output logic                  m0_ar_ready_o,
   input  logic [ADDR_WIDTH-1:0] m0_ar_addr_i,
   output logic                  m0_r_valid_o,
   input  logic                  m0_r_ready_i,
   output logic [DATA_WIDTH-1:0] m0_r_data_o,
   input  logic                  m1_ar_valid_i,
   output logic                  m1_ar_ready_o,
   input  logic [ADDR_WIDTH-1:0] m1_ar_addr_i,
   output logic                  m1_r_valid_o,
   input  logic                  m1_r_ready_i,
   output logic [DATA_WIDTH-1:0] m1_r_data_o,
   output logic                  s_ar_valid_o,
   input  logic                  s_ar_ready_i,
   output logic [ADDR_WIDTH-1:0] s_ar_addr_o,
   input  logic                  s_r_valid_i,
   output logic                  s_r_ready_o,
   input  logic [DATA_WIDTH-1:0] s_r_data_i
);
   logic [SARRAY_ARB_NUM_REQ-1:0] req;
   arb_tag_t grant;
   arb_tag_t lock_id_reg;
   logic     lock_valid_reg;
   arb_tag_t head_tag;
   logic     fifo_full;
   logic     fifo_empty;
   logic     ar_hs;
   logic     r_hs;

   assign req = {m1_ar_valid_i, m0_ar_valid_i};

`ifdef SARRAY_RD_ARB_RR_EN
   // Resets to 1 so the first contended grant after reset goes to m0.
   arb_tag_t last_grant_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     last_grant_reg <= 1'b1;
      else if (ar_hs) last_grant_reg <= grant;
   end

   always_comb begin
      grant = 1'b0;
      if (lock_valid_reg)   grant = lock_id_reg;
      else if (&req)        grant = ~last_grant_reg;
      else if (req[1])      grant = 1'b1;
   end
`else
   always_comb begin
      grant = 1'b0;
      if (lock_valid_reg)   grant = lock_id_reg;
      else if (!req[0])     grant = 1'b1;
   end
`endif

   // rst_n gating keeps every valid/ready output low while reset is held,
   // even if requesters are already presenting valid.
   assign s_ar_valid_o  = rst_n & req[grant] & ~fifo_full;
   assign s_ar_addr_o   = !rst_n ? '0 : (grant == 1'b1 ? m1_ar_addr_i : m0_ar_addr_i);
   assign m0_ar_ready_o = rst_n & (grant == 1'b0) & s_ar_ready_i & ~fifo_full;
   assign m1_ar_ready_o = rst_n & (grant == 1'b1) & s_ar_ready_i & ~fifo_full;
   assign ar_hs         = s_ar_valid_o & s_ar_ready_i;

   // Hold the winner while its request is offered but not yet accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_valid_reg <= 1'b0;
         lock_id_reg    <= 1'b0;
      end else if (ar_hs) begin
         lock_valid_reg <= 1'b0;
      end else if (s_ar_valid_o) begin
         lock_valid_reg <= 1'b1;
         lock_id_reg    <= grant;
      end
   end

   sarray_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH ($bits(arb_tag_t))
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ar_hs),
      .push_data (grant),
      .pop       (r_hs),
      .head_data (head_tag),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign m0_r_valid_o = s_r_valid_i & ~fifo_empty & (head_tag == 1'b0);
   assign m1_r_valid_o = s_r_valid_i & ~fifo_empty & (head_tag == 1'b1);
   assign s_r_ready_o  = ~fifo_empty & (head_tag == 1'b1 ? m1_r_ready_i : m0_r_ready_i);
   assign r_hs         = s_r_valid_i & s_r_ready_o;
   assign m0_r_data_o  = s_r_data_i;
   assign m1_r_data_o  = s_r_data_i;

   // A response with nothing outstanding means downstream is out of step.
   a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
      !(s_r_valid_i && fifo_empty))
      else $error("sarray_rd_arb: response beat with no outstanding request");
endmodule

// File: tb/tb_sarray_rd_arb.sv
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 32
`endif

module tb_sarray_rd_arb;
   localparam int AW = `ADDR_WIDTH;
   localparam int DW = `SARRAY_LOAD_WIDTH;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_ar_valid_i, m1_ar_valid_i;
   logic          m0_ar_ready_o, m1_ar_ready_o;
   logic [AW-1:0] m0_ar_addr_i, m1_ar_addr_i;
   logic          m0_r_valid_o, m1_r_valid_o;
   logic          m0_r_ready_i, m1_r_ready_i;
   logic [DW-1:0] m0_r_data_o, m1_r_data_o;
   logic          s_ar_valid_o, s_ar_ready_i;
   logic [AW-1:0] s_ar_addr_o;
   logic          s_r_valid_i, s_r_ready_o;
   logic [DW-1:0] s_r_data_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sarray_rd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_ready_o(m0_ar_ready_o), .m0_ar_addr_i(m0_ar_addr_i),
      .m0_r_valid_o(m0_r_valid_o), .m0_r_ready_i(m0_r_ready_i), .m0_r_data_o(m0_r_data_o),
      .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_ready_o(m1_ar_ready_o), .m1_ar_addr_i(m1_ar_addr_i),
      .m1_r_valid_o(m1_r_valid_o), .m1_r_ready_i(m1_r_ready_i), .m1_r_data_o(m1_r_data_o),
      .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready_i), .s_ar_addr_o(s_ar_addr_o),
      .s_r_valid_i(s_r_valid_i), .s_r_ready_o(s_r_ready_o), .s_r_data_i(s_r_data_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [AW-1:0] exp_addr [4];
   logic          exp_tag  [4];

   initial begin
      rst_n = 1'b0;
      m0_ar_valid_i = 1'b1; m0_ar_addr_i = '0;
      m1_ar_valid_i = 1'b0; m1_ar_addr_i = '0;
      m0_r_ready_i = 1'b0;  m1_r_ready_i = 1'b0;
      s_ar_ready_i = 1'b1;  s_r_valid_i = 1'b0;
      s_r_data_i = DW'('h5A);

      // Reset: outputs quiet even though m0 is requesting.
      #1;
      chk("rst_s_ar_valid", 64'(s_ar_valid_o), 64'd0);
      chk("rst_m0_ar_ready", 64'(m0_ar_ready_o), 64'd0);
      chk("rst_s_r_ready", 64'(s_r_ready_o), 64'd0);
      chk("rst_m0_r_data", 64'(m0_r_data_o), 64'h5A);
      tick(); tick();
      m0_ar_valid_i = 1'b0;
      rst_n = 1'b1;
      tick();
      $display("reset released");

      // Contention: both valid for 4 cycles.
`ifdef SARRAY_RD_ARB_RR_EN
      exp_addr[0] = AW'('h0); exp_addr[1] = AW'('h1000);
      exp_addr[2] = AW'('h0); exp_addr[3] = AW'('h1000);
      exp_tag[0] = 1'b0; exp_tag[1] = 1'b1; exp_tag[2] = 1'b0; exp_tag[3] = 1'b1;
`else
      for (int i = 0; i < 4; i++) begin
         exp_addr[i] = AW'('h0);
         exp_tag[i]  = 1'b0;
      end
`endif
      m0_ar_valid_i = 1'b1; m0_ar_addr_i = AW'('h0);
      m1_ar_valid_i = 1'b1; m1_ar_addr_i = AW'('h1000);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("cont_addr%0d", i), 64'(s_ar_addr_o), 64'(exp_addr[i]));
         chk($sformatf("cont_valid%0d", i), 64'(s_ar_valid_o), 64'd1);
         $display("AR grant %0d addr=%0h", i, s_ar_addr_o);
         tick();
      end
      m0_ar_valid_i = 1'b0; m1_ar_valid_i = 1'b0;
      m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b1;
      s_r_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_r_data_i = DW'(32'h10 + i);
         #1;
         chk($sformatf("cont_r_m0_%0d", i), 64'(m0_r_valid_o), 64'(!exp_tag[i]));
         chk($sformatf("cont_r_m1_%0d", i), 64'(m1_r_valid_o), 64'(exp_tag[i]));
         $display("R beat %0d m0=%0b m1=%0b", i, m0_r_valid_o, m1_r_valid_o);
         tick();
      end
      s_r_valid_i = 1'b0;

      // Single request then its response one cycle later.
      m0_ar_valid_i = 1'b1; m0_ar_addr_i = AW'('h0);
      #1;
      chk("single_ar_valid", 64'(s_ar_valid_o), 64'd1);
      chk("single_ar_addr", 64'(s_ar_addr_o), 64'h0);
      chk("single_m0_ready", 64'(m0_ar_ready_o), 64'd1);
      chk("single_m1_ready", 64'(m1_ar_ready_o), 64'd0);
      tick();
      m0_ar_valid_i = 1'b0;
      s_r_valid_i = 1'b1; s_r_data_i = DW'('hA5);
      #1;
      chk("single_m0_r_valid", 64'(m0_r_valid_o), 64'd1);
      chk("single_m0_r_data", 64'(m0_r_data_o), 64'hA5);
      chk("single_m1_r_valid", 64'(m1_r_valid_o), 64'd0);
      chk("single_s_r_ready", 64'(s_r_ready_o), 64'd1);
      $display("single request/response done");
      tick();
      s_r_valid_i = 1'b0;

      // Grant lock: m1 pending, m0 arrives while downstream stalls.
      s_ar_ready_i = 1'b0;
      m1_ar_valid_i = 1'b1; m1_ar_addr_i = AW'('h1000);
      #1;
      chk("lock_c1_addr", 64'(s_ar_addr_o), 64'h1000);
      chk("lock_c1_m1_ready", 64'(m1_ar_ready_o), 64'd0);
      tick();
      m0_ar_valid_i = 1'b1; m0_ar_addr_i = AW'('h0);
      #1;
      chk("lock_c2_addr", 64'(s_ar_addr_o), 64'h1000);
      tick();
      chk("lock_c3_addr", 64'(s_ar_addr_o), 64'h1000);
      tick();
      s_ar_ready_i = 1'b1;
      #1;
      chk("lock_hs_addr", 64'(s_ar_addr_o), 64'h1000);
      chk("lock_hs_m1_ready", 64'(m1_ar_ready_o), 64'd1);
      chk("lock_hs_m0_ready", 64'(m0_ar_ready_o), 64'd0);
      tick();
      m1_ar_valid_i = 1'b0;
      #1;
      chk("lock_next_addr", 64'(s_ar_addr_o), 64'h0);
      chk("lock_next_m0_ready", 64'(m0_ar_ready_o), 64'd1);
      $display("grant lock done");
      tick();
      m0_ar_valid_i = 1'b0;

      // Backpressure: head tag is m1 (then m0).
      s_r_valid_i = 1'b1; s_r_data_i = DW'('h77);
      m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b0;
      #1;
      chk("bp_s_r_ready", 64'(s_r_ready_o), 64'd0);
      chk("bp_m1_r_valid", 64'(m1_r_valid_o), 64'd1);
      chk("bp_m0_r_valid", 64'(m0_r_valid_o), 64'd0);
      tick();
      chk("bp_hold_m1_r_valid", 64'(m1_r_valid_o), 64'd1);
      chk("bp_hold_data", 64'(m1_r_data_o), 64'h77);
      m1_r_ready_i = 1'b1;
      #1;
      chk("bp_release_ready", 64'(s_r_ready_o), 64'd1);
      tick();
      chk("bp_next_m0_valid", 64'(m0_r_valid_o), 64'd1);
      chk("bp_next_m1_valid", 64'(m1_r_valid_o), 64'd0);
      $display("backpressure done");
      tick();
      s_r_valid_i = 1'b0;

      // Full: 8 handshakes with no responses.
      m0_ar_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m0_ar_addr_i = AW'(i * 4);
         tick();
      end
      m1_ar_valid_i = 1'b1;
      #1;
      chk("full_s_ar_valid", 64'(s_ar_valid_o), 64'd0);
      chk("full_m0_ready", 64'(m0_ar_ready_o), 64'd0);
      chk("full_m1_ready", 64'(m1_ar_ready_o), 64'd0);
      m1_ar_valid_i = 1'b0;
      s_r_valid_i = 1'b1;
      #1;
      chk("full_pop_same_cycle_blocked", 64'(s_ar_valid_o), 64'd0);
      chk("full_pop_ready", 64'(s_r_ready_o), 64'd1);
      tick();
      s_r_valid_i = 1'b0;
      #1;
      chk("full_resume_valid", 64'(s_ar_valid_o), 64'd1);
      chk("full_resume_m0_ready", 64'(m0_ar_ready_o), 64'd1);
      $display("full boundary done");
      m0_ar_valid_i = 1'b0;
      tick();

      // Drain to 3 outstanding, then reset mid-operation.
      s_r_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      s_r_valid_i = 1'b0;
      rst_n = 1'b0;
      m0_ar_valid_i = 1'b1; m1_ar_valid_i = 1'b1;
      m0_ar_addr_i = AW'('h40); m1_ar_addr_i = AW'('h1000);
      #1;
      chk("midrst_s_ar_valid", 64'(s_ar_valid_o), 64'd0);
      chk("midrst_m0_ready", 64'(m0_ar_ready_o), 64'd0);
      chk("midrst_m1_ready", 64'(m1_ar_ready_o), 64'd0);
      chk("midrst_addr", 64'(s_ar_addr_o), 64'h0);
      tick(); tick();
      m0_ar_valid_i = 1'b0; m1_ar_valid_i = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("postrst_empty", 64'(s_r_ready_o), 64'd0);
      tick();
      m0_ar_valid_i = 1'b1; m1_ar_valid_i = 1'b1;
      #1;
      chk("postrst_addr", 64'(s_ar_addr_o), 64'h40);
      chk("postrst_m0_ready", 64'(m0_ar_ready_o), 64'd1);
      chk("postrst_m1_ready", 64'(m1_ar_ready_o), 64'd0);
      $display("reset mid-operation done");
      tick();
      m0_ar_valid_i = 1'b0; m1_ar_valid_i = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
